// File: rtl/clock_pkg.sv
// Shared mode encoding, counter limits and databus grant codes for the clock sequencer.
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2,
        MODE_SET_SEC  = 2'd3
    } mode_t;

    localparam logic [5:0] MAX_SEC  = 6'd59;
    localparam logic [5:0] MAX_MIN  = 6'd59;
    localparam logic [5:0] MAX_HOUR = 6'd23;

    localparam logic [2:0] BUS_SEC  = 3'b001;
    localparam logic [2:0] BUS_MIN  = 3'b010;
    localparam logic [2:0] BUS_HOUR = 3'b100;

    // Anything at or beyond the limit, including out-of-range values, wraps to 0.
    function automatic logic [5:0] wrap_inc(input logic [5:0] value, input logic [5:0] limit);
        return (value >= limit) ? 6'd0 : value + 6'd1;
    endfunction

endpackage

// File: rtl/clock_sequencer_edge_pulse.sv
// Rising-edge detector for a level already synchronised to clk; history clears asynchronously.
module edge_pulse (
    input  logic i_clk,
    input  logic i_clear_n,
    input  logic i_level,
    output logic o_rise
);

    logic r_level_q;

    always_ff @(posedge i_clk or negedge i_clear_n) begin
        if (!i_clear_n) begin
            r_level_q <= 1'b0;
        end else begin
            r_level_q <= i_level;
        end
    end

    assign o_rise = i_level & ~r_level_q;

endmodule

// File: rtl/clock_sequencer.sv
// Clock sequencer: 1 Hz prescaler with carry cascade, button-driven set FSM and
// round-robin databus scanner for the seconds/minutes/hours slices.
module clock_sequencer
    import clock_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned SCAN_DIV = 50_000
) (
    input  logic       clk,
    input  logic       clear_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [5:0] sec_in,
    input  logic [5:0] min_in,
    input  logic [4:0] hour_in,
    output logic       sec_adv,
    output logic       min_adv,
    output logic       hour_adv,
    output logic       sec_ld,
    output logic       min_ld,
    output logic       hour_ld,
    output logic [5:0] ld_data,
    output logic [2:0] bus_en,
    output logic [1:0] mode
);

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SW = $clog2(SCAN_DIV + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    logic w_mode_rise;
    logic w_inc_rise;

    mode_t         r_state;
    mode_t         w_state_nxt;
    logic [TW-1:0] r_tick_cnt;
    logic [TW-1:0] w_tick_nxt;
    logic [SW-1:0] r_scan_cnt;
    logic [2:0]    r_bus_en;

    logic       r_sec_adv, r_min_adv, r_hour_adv;
    logic       r_sec_ld, r_min_ld, r_hour_ld;
    logic [5:0] r_ld_data;
    logic       w_sec_adv, w_min_adv, w_hour_adv;
    logic       w_sec_ld, w_min_ld, w_hour_ld;
    logic [5:0] w_ld_data;

    edge_pulse u_mode_edge (
        .i_clk     (clk),
        .i_clear_n (clear_n),
        .i_level   (btn_mode),
        .o_rise    (w_mode_rise)
    );

    edge_pulse u_inc_edge (
        .i_clk     (clk),
        .i_clear_n (clear_n),
        .i_level   (btn_inc),
        .o_rise    (w_inc_rise)
    );

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_state    <= MODE_RUN;
            r_tick_cnt <= '0;
            r_sec_adv  <= 1'b0;
            r_min_adv  <= 1'b0;
            r_hour_adv <= 1'b0;
            r_sec_ld   <= 1'b0;
            r_min_ld   <= 1'b0;
            r_hour_ld  <= 1'b0;
            r_ld_data  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_tick_cnt <= w_tick_nxt;
            r_sec_adv  <= w_sec_adv;
            r_min_adv  <= w_min_adv;
            r_hour_adv <= w_hour_adv;
            r_sec_ld   <= w_sec_ld;
            r_min_ld   <= w_min_ld;
            r_hour_ld  <= w_hour_ld;
            r_ld_data  <= w_ld_data;
        end
    end

    // A mode rise takes priority over both the tick wrap and an inc rise in the same cycle,
    // so advance and load strobes only ever appear while the FSM is settled in a mode.
    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = '0;
        w_sec_adv   = 1'b0;
        w_min_adv   = 1'b0;
        w_hour_adv  = 1'b0;
        w_sec_ld    = 1'b0;
        w_min_ld    = 1'b0;
        w_hour_ld   = 1'b0;
        w_ld_data   = '0;
        case (r_state)
            MODE_RUN: begin
                if (w_mode_rise) begin
                    w_state_nxt = MODE_SET_HOUR;
                end else if (r_tick_cnt == TICK_LAST) begin
                    w_sec_adv  = 1'b1;
                    w_min_adv  = (sec_in == MAX_SEC);
                    w_hour_adv = (sec_in == MAX_SEC) && (min_in == MAX_MIN);
                end else begin
                    w_tick_nxt = r_tick_cnt + 1'b1;
                end
            end
            MODE_SET_HOUR: begin
                if (w_mode_rise) begin
                    w_state_nxt = MODE_SET_MIN;
                end else if (w_inc_rise) begin
                    w_hour_ld = 1'b1;
                    w_ld_data = wrap_inc({1'b0, hour_in}, MAX_HOUR);
                end
            end
            MODE_SET_MIN: begin
                if (w_mode_rise) begin
                    w_state_nxt = MODE_SET_SEC;
                end else if (w_inc_rise) begin
                    w_min_ld  = 1'b1;
                    w_ld_data = wrap_inc(min_in, MAX_MIN);
                end
            end
            MODE_SET_SEC: begin
                if (w_mode_rise) begin
                    w_state_nxt = MODE_RUN;
                end else if (w_inc_rise) begin
                    w_sec_ld = 1'b1;
                end
            end
            default: begin
                w_state_nxt = MODE_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_scan_cnt <= '0;
            r_bus_en   <= BUS_SEC;
        end else if (r_scan_cnt == SCAN_LAST) begin
            r_scan_cnt <= '0;
            r_bus_en   <= {r_bus_en[1:0], r_bus_en[2]};
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    assign sec_adv  = r_sec_adv;
    assign min_adv  = r_min_adv;
    assign hour_adv = r_hour_adv;
    assign sec_ld   = r_sec_ld;
    assign min_ld   = r_min_ld;
    assign hour_ld  = r_hour_ld;
    assign ld_data  = r_ld_data;
    assign bus_en   = r_bus_en;
    assign mode     = r_state;

endmodule
